mult_arb: RTL and testbench
===========================

MULT_ARB -- requirements
Module: mult_arb

Interface
REQ-001 The block SHALL have parameter N, default 4, the operand width in bits.
REQ-002 The block SHALL have localparam M = 2*N, the product width in bits.
REQ-003 Port clk SHALL be input, width 1: the single clock; all state updates on rising edge.
REQ-004 Port rst_n SHALL be input, width 1: reset, synchronous and active-low.
REQ-005 Ports req0_valid and req1_valid SHALL be inputs, width 1: client k has an operand pair pending.
REQ-006 Ports req0_ready and req1_ready SHALL be outputs, width 1: client k's pair is accepted this cycle.
REQ-007 Ports req0_op1, req0_op2, req1_op1 and req1_op2 SHALL be inputs, width N: two's-complement operands of client k.
REQ-008 Ports rsp0_valid and rsp1_valid SHALL be outputs, width 1: a result is presented to client k.
REQ-009 Ports rsp0_data and rsp1_data SHALL be outputs, width M: the signed product for client k.
REQ-010 Ports rsp0_ready and rsp1_ready SHALL be inputs, width 1: client k takes its result.
REQ-011 Port busy SHALL be output, width 1: high whenever the state is not IDLE.

Function
REQ-012 The block SHALL instantiate exactly one combinational mult (op1, op2 -> out), shared by both clients.
REQ-013 The block SHALL implement an FSM with states IDLE, EXEC and RESP.
REQ-014 In IDLE, the block SHALL grant at most one client; reqK_ready = reqK_valid AND grantK, combinational, and both ready signals SHALL be low outside IDLE.
REQ-015 Grant rules SHALL be as follows:
- Only one client valid: that client is granted.
- Both clients valid: the client not granted last is granted (round-robin).
- The last-grant pointer updates only on an accept.
- After reset the pointer favours client 0.
REQ-016 On accept (valid AND ready) in cycle T, the block SHALL register the operands and the client ID, then enter EXEC.
REQ-017 In EXEC, the block SHALL drive mult from the operand registers, capture out into the result register, then enter RESP.
REQ-018 In RESP, rspK_valid SHALL be high only for the registered ID, and rspK_data SHALL equal the result register.
REQ-019 In RESP, the state SHALL stay RESP until the matching rspK_ready is high, then go to IDLE.
REQ-020 A new accept SHALL NOT occur in the cycle the RESP->IDLE transition is taken.
REQ-021 Latency from accept at T to rspK_valid SHALL be T+2.
REQ-022 Minimum accept-to-accept spacing SHALL be 3 cycles.
REQ-023 The non-addressed rsp_valid SHALL be low at all times, and rsp_ready from the non-addressed client SHALL be ignored.
REQ-024 rspK_data SHALL hold stable while rspK_valid is high and unacknowledged; outside RESP it SHALL hold the last result.
REQ-025 Arithmetic SHALL be rsp_data = signed(op1) * signed(op2), full M-bit width, no overflow possible.
REQ-026 The most-negative operand pair SHALL be handled: N=4, -8 * -8 = +64 = 01000000.
REQ-027 Valid deasserted before accept SHALL cancel that request silently; no state change.
REQ-028 A pending request from the non-granted client SHALL wait, with no loss and no starvation: it is served on the next accept.

Reset
REQ-029 With rst_n low at a rising edge, the block SHALL set state to IDLE, the grant pointer to client 0, and the operand, ID and result registers to 0.
REQ-030 Reset SHALL override every other condition, including mid-EXEC and mid-RESP; an in-flight result is discarded and never presented.
REQ-031 During and immediately after reset: all ready and rsp_valid low, busy low, rsp_data 0.

Verification
REQ-032 The bench SHALL cover a single client: req0 1001 x 0001, rsp0_ready=1 -> rsp0_valid at T+2, rsp0_data=11111001 (-7), busy high T+1..T+2.
REQ-033 The bench SHALL cover a simultaneous request after reset: req0 1001x1001 and req1 1011x1010 -> client 0 first (00110001), then client 1 (00011110), rsp1_valid never overlaps rsp0_valid.
REQ-034 The bench SHALL cover fairness: both clients held valid for 6 transactions -> grants alternate 0,1,0,1,0,1 with 3-cycle spacing.
REQ-035 The bench SHALL cover backpressure: rsp1_ready low 5 cycles with result 0111x0111 -> state RESP held, rsp1_data=00110001 stable, req0_ready low throughout, accept of client 0 only after handshake.
REQ-036 The bench SHALL cover mid-operation reset: rst_n low during EXEC -> next cycle IDLE, no rsp_valid, next transaction 1000x1000 -> 01000000.
REQ-037 The bench SHALL cover exhaustive arithmetic: all 256 N=4 operand pairs through client 0 -> each rsp0_data equals the signed-reference product.

Source files
------------

// File: rtl/mult_arb.sv
// Two-client arbiter in front of one shared signed multiplier.
// A client's operand pair is accepted in IDLE. The product is computed in
// EXEC and held in RESP until the owning client takes it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Request ready is a combinational function of valid, so a client
// may drop valid before acceptance, which cancels the request. Response valid
// stays high, with stable data, until the addressed client raises its ready.

module mult #(
    parameter int N = 4
) (
    input  logic [N-1:0]   op1_i,
    input  logic [N-1:0]   op2_i,
    output logic [2*N-1:0] out_o
);
    // Sign-extend both operands to full width. The low 2N bits of the
    // unsigned product then equal the two's-complement product.
    assign out_o = {{N{op1_i[N-1]}}, op1_i} * {{N{op2_i[N-1]}}, op2_i};
endmodule

module mult_arb #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N-1:0]   req0_op1,
    input  logic [N-1:0]   req0_op2,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N-1:0]   req1_op1,
    input  logic [N-1:0]   req1_op2,
    output logic           rsp0_valid,
    output logic [2*N-1:0] rsp0_data,
    input  logic           rsp0_ready,
    output logic           rsp1_valid,
    output logic [2*N-1:0] rsp1_data,
    input  logic           rsp1_ready,
    output logic           busy,
    output logic [1:0]     state_o
);
    localparam int M = 2 * N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           ptr_q, ptr_d;   // client favoured when both are valid
    logic           id_q, id_d;     // client owning the in-flight operation
    logic [N-1:0]   op1_q, op1_d;
    logic [N-1:0]   op2_q, op2_d;
    logic [M-1:0]   res_q, res_d;
    logic [M-1:0]   mult_out;
    logic           grant0, grant1;

    mult #(.N(N)) u_mult (
        .op1_i (op1_q),
        .op2_i (op2_q),
        .out_o (mult_out)
    );

    // State and datapath registers; reset discards any in-flight result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            res_q   <= res_d;
        end
    end

    // Arbitration, next-state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        res_d      = res_q;
        grant0     = 1'b0;
        grant1     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state_q)
            IDLE: begin
                grant0     = req0_valid & (~req1_valid | ~ptr_q);
                grant1     = req1_valid & (~req0_valid | ptr_q);
                req0_ready = rst_n & grant0;
                req1_ready = rst_n & grant1;
                if (req0_ready) begin
                    op1_d   = req0_op1;
                    op2_d   = req0_op2;
                    id_d    = 1'b0;
                    ptr_d   = 1'b1;
                    state_d = EXEC;
                end else if (req1_ready) begin
                    op1_d   = req1_op1;
                    op2_d   = req1_op2;
                    id_d    = 1'b1;
                    ptr_d   = 1'b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = mult_out;
                state_d = RESP;
            end
            RESP: begin
                rsp0_valid = rst_n & ~id_q;
                rsp1_valid = rst_n & id_q;
                if ((~id_q & rsp0_ready) | (id_q & rsp1_ready)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp0_data = res_q;
    assign rsp1_data = res_q;
    assign busy      = (state_q != IDLE);
    assign state_o   = state_q;
endmodule

// File: tb/tb_mult_arb.sv
// Bench for mult_arb: directed scenarios plus a randomized run checked
// against a transaction-level reference model.
module tb_mult_arb;
  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [7:0] rsp0_data, rsp1_data;
  logic       busy;
  logic [1:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  mult_arb #(.N(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op1   (req0_op1),
    .req0_op2   (req0_op2),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op1   (req1_op1),
    .req1_op2   (req1_op2),
    .rsp0_valid (rsp0_valid),
    .rsp0_data  (rsp0_data),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_data  (rsp1_data),
    .rsp1_ready (rsp1_ready),
    .busy       (busy),
    .state_o    (state_dbg)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // reference arithmetic
  function automatic int sx(input logic [3:0] v);
    return (v >= 4'd8) ? int'(v) - 16 : int'(v);
  endfunction

  function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
    int p;
    p = sx(a) * sx(b);
    return p[7:0];
  endfunction

  // driver tasks
  task automatic clear_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op1 = 4'd0; req0_op2 = 4'd0; req1_op1 = 4'd0; req1_op2 = 4'd0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      n_tests++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req0_ready: got %b want 0", req0_ready); end
      n_tests++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req1_ready: got %b want 0", req1_ready); end
      n_tests++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b%b want 00", rsp0_valid, rsp1_valid); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_tests++; if (rsp0_data !== 8'h00 || rsp1_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h/%h want 00", rsp0_data, rsp1_data); end
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    #1;
    n_tests++; if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle: busy %b rsp0_valid %b want 0 0", busy, rsp0_valid); end
  endtask

  task automatic test_single();
    @(negedge clk);
    req0_valid = 1'b1; req0_op1 = 4'b1001; req0_op2 = 4'b0001; rsp0_ready = 1'b1;
    #1;
    n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_t1: got %b want 1", busy); end
    n_tests++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_rsp: got %b want 0", rsp0_valid); end
    @(negedge clk); #1;
    n_tests++; if (rsp0_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_t2: got %b want 1", rsp0_valid); end
    n_tests++; if (rsp0_data !== 8'b11111001) begin n_fail++; $display("FAIL single_data: got %b want 11111001", rsp0_data); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_t2: got %b want 1", busy); end
    n_tests++; if (rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp1: got %b want 0", rsp1_valid); end
    @(negedge clk); #1;
    n_tests++; if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL single_done: busy %b rsp0_valid %b want 0 0", busy, rsp0_valid); end
    rsp0_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    int r0c, r1c, a1c;
    logic [7:0] d0, d1;
    bit ov;
    r0c = -1; r1c = -1; a1c = -1; d0 = '0; d1 = '0; ov = 1'b0;
    apply_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_op1 = 4'b1001; req0_op2 = 4'b1001;
    req1_valid = 1'b1; req1_op1 = 4'b1011; req1_op2 = 4'b1010;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    n_tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL simul_grant: got %b%b want 10", req0_ready, req1_ready); end
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      req0_valid = 1'b0;
      if (a1c >= 0) req1_valid = 1'b0;
      #1;
      if (rsp0_valid === 1'b1 && rsp1_valid === 1'b1) ov = 1'b1;
      if (rsp0_valid === 1'b1 && r0c < 0) begin r0c = c; d0 = rsp0_data; end
      if (rsp1_valid === 1'b1 && r1c < 0) begin r1c = c; d1 = rsp1_data; end
      if (req1_ready === 1'b1 && a1c < 0) a1c = c;
    end
    n_tests++; if (r0c != 2) begin n_fail++; $display("FAIL simul_rsp0_cycle: got %0d want 2", r0c); end
    n_tests++; if (d0 !== 8'b00110001) begin n_fail++; $display("FAIL simul_rsp0_data: got %b want 00110001", d0); end
    n_tests++; if (a1c != 3) begin n_fail++; $display("FAIL simul_accept1_cycle: got %0d want 3", a1c); end
    n_tests++; if (r1c != 5) begin n_fail++; $display("FAIL simul_rsp1_cycle: got %0d want 5", r1c); end
    n_tests++; if (d1 !== 8'b00011110) begin n_fail++; $display("FAIL simul_rsp1_data: got %b want 00011110", d1); end
    n_tests++; if (ov) begin n_fail++; $display("FAIL simul_overlap: got 1 want 0"); end
    clear_inputs();
  endtask

  task automatic test_fairness();
    int gid[$];
    int gcyc[$];
    logic [7:0] exp_q[$];
    logic [7:0] e;
    apply_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      req0_valid = (gid.size() < 6); req1_valid = (gid.size() < 6);
      req0_op1 = 4'($urandom_range(0, 15)); req0_op2 = 4'($urandom_range(0, 15));
      req1_op1 = 4'($urandom_range(0, 15)); req1_op2 = 4'($urandom_range(0, 15));
      #1;
      if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_tests++;
        if ((rsp0_valid === 1'b1 ? rsp0_data : rsp1_data) !== e) begin
          n_fail++; $display("FAIL fair_data: got %h want %h", rsp0_valid === 1'b1 ? rsp0_data : rsp1_data, e);
        end
      end
      if (req0_ready === 1'b1) begin gid.push_back(0); gcyc.push_back(c); exp_q.push_back(ref_mul(req0_op1, req0_op2)); end
      else if (req1_ready === 1'b1) begin gid.push_back(1); gcyc.push_back(c); exp_q.push_back(ref_mul(req1_op1, req1_op2)); end
    end
    n_tests++; if (gid.size() != 6) begin n_fail++; $display("FAIL fair_count: got %0d want 6", gid.size()); end
    for (int i = 0; i < gid.size(); i++) begin
      n_tests++; if (gid[i] != i % 2) begin n_fail++; $display("FAIL fair_order[%0d]: got %0d want %0d", i, gid[i], i % 2); end
      if (i > 0) begin
        n_tests++; if (gcyc[i] - gcyc[i-1] != 3) begin n_fail++; $display("FAIL fair_spacing[%0d]: got %0d want 3", i, gcyc[i] - gcyc[i-1]); end
      end
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    apply_reset();
    @(negedge clk);
    req1_valid = 1'b1; req1_op1 = 4'b0111; req1_op2 = 4'b0111; rsp1_ready = 1'b0; rsp0_ready = 1'b1;
    #1;
    n_tests++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept1: got %b want 1", req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0; req0_valid = 1'b1; req0_op1 = 4'b0010; req0_op2 = 4'b0011;
    #1;
    n_tests++; if (req0_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_exec: ready %b busy %b want 0 1", req0_ready, busy); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      n_tests++; if (rsp1_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", k, rsp1_valid); end
      n_tests++; if (rsp1_data !== 8'b00110001) begin n_fail++; $display("FAIL bp_hold_data[%0d]: got %b want 00110001", k, rsp1_data); end
      n_tests++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req0_blocked[%0d]: got %b want 0", k, req0_ready); end
      n_tests++; if (rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL bp_rsp0_quiet[%0d]: got %b want 0", k, rsp0_valid); end
    end
    @(negedge clk);
    rsp1_ready = 1'b1;
    #1;
    n_tests++; if (rsp1_valid !== 1'b1 || req0_ready !== 1'b0) begin n_fail++; $display("FAIL bp_handshake: valid %b ready0 %b want 1 0", rsp1_valid, req0_ready); end
    @(negedge clk);
    rsp1_ready = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b0 || rsp1_valid !== 1'b0 || req0_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept0: busy %b valid1 %b ready0 %b want 0 0 1", busy, rsp1_valid, req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk); #1;
    n_tests++; if (rsp0_valid !== 1'b1 || rsp0_data !== 8'h06) begin n_fail++; $display("FAIL bp_rsp0: valid %b data %h want 1 06", rsp0_valid, rsp0_data); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_mid_reset();
    apply_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_op1 = 4'b0011; req0_op2 = 4'b0011; rsp0_ready = 1'b1;
    #1;
    n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL mr_accept: got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0; rst_n = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mr_exec_busy: got %b want 1", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mr_idle: got %b want 0", busy); end
    n_tests++; if (rsp0_data !== 8'h00) begin n_fail++; $display("FAIL mr_data_cleared: got %h want 00", rsp0_data); end
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL mr_no_rsp[%0d]: got %b%b want 00", k, rsp0_valid, rsp1_valid); end
      @(negedge clk); #1;
    end
    @(negedge clk);
    req0_valid = 1'b1; req0_op1 = 4'b1000; req0_op2 = 4'b1000;
    #1;
    n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL mr_accept2: got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk); #1;
    n_tests++; if (rsp0_valid !== 1'b1 || rsp0_data !== 8'b01000000) begin n_fail++; $display("FAIL mr_mostneg: valid %b data %b want 1 01000000", rsp0_valid, rsp0_data); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_exhaustive();
    logic [3:0] a, b;
    logic [7:0] e;
    rsp0_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a = 4'(i / 16); b = 4'(i % 16); e = ref_mul(a, b);
      @(negedge clk);
      req0_valid = 1'b1; req0_op1 = a; req0_op2 = b;
      #1;
      n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL exh_accept %h*%h: got %b want 1", a, b, req0_ready); end
      @(negedge clk);
      req0_valid = 1'b0;
      @(negedge clk); #1;
      n_tests++; if (rsp0_valid !== 1'b1 || rsp0_data !== e) begin n_fail++; $display("FAIL exh_prod %h*%h: valid %b data %h want 1 %h", a, b, rsp0_valid, rsp0_data, e); end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  // randomized traffic against a transaction-level model: one operation
  // in flight, response two cycles after accept, round-robin on contention
  task automatic test_random();
    logic [7:0] exp_q[$];
    bit m_busy, m_id, m_ptr, e0, e1, ev0, ev1;
    int m_acc;
    m_busy = 1'b0; m_id = 1'b0; m_ptr = 1'b0; m_acc = 0;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      req0_valid = ($urandom_range(0, 99) < 60); req1_valid = ($urandom_range(0, 99) < 60);
      req0_op1 = 4'($urandom_range(0, 15)); req0_op2 = 4'($urandom_range(0, 15));
      req1_op1 = 4'($urandom_range(0, 15)); req1_op2 = 4'($urandom_range(0, 15));
      rsp0_ready = 1'($urandom_range(0, 1)); rsp1_ready = 1'($urandom_range(0, 1));
      #1;
      e0 = 1'b0; e1 = 1'b0;
      if (!m_busy) begin
        if (req0_valid && (!req1_valid || !m_ptr)) e0 = 1'b1;
        else if (req1_valid) e1 = 1'b1;
      end
      ev0 = m_busy && (c >= m_acc + 2) && !m_id;
      ev1 = m_busy && (c >= m_acc + 2) && m_id;
      n_tests++; if (req0_ready !== e0 || req1_ready !== e1) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b%b want %b%b", c, req0_ready, req1_ready, e0, e1); end
      n_tests++; if (rsp0_valid !== ev0 || rsp1_valid !== ev1) begin n_fail++; $display("FAIL rnd_rsp_valid c%0d: got %b%b want %b%b", c, rsp0_valid, rsp1_valid, ev0, ev1); end
      n_tests++; if (busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, m_busy); end
      if ((ev0 || ev1) && exp_q.size() > 0) begin
        n_tests++;
        if ((ev0 ? rsp0_data : rsp1_data) !== exp_q[0]) begin
          n_fail++; $display("FAIL rnd_data c%0d: got %h want %h", c, ev0 ? rsp0_data : rsp1_data, exp_q[0]);
        end
        if ((ev0 && rsp0_ready) || (ev1 && rsp1_ready)) begin
          void'(exp_q.pop_front());
          m_busy = 1'b0;
        end
      end
      if (e0) begin exp_q.push_back(ref_mul(req0_op1, req0_op2)); m_busy = 1'b1; m_id = 1'b0; m_ptr = 1'b1; m_acc = c; end
      if (e1) begin exp_q.push_back(ref_mul(req1_op1, req1_op2)); m_busy = 1'b1; m_id = 1'b1; m_ptr = 1'b0; m_acc = c; end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_mid_reset();
    test_exhaustive();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
